// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU timing/control slice.
package cpu_pkg;

  localparam int unsigned RING_W             = 10;
  localparam int unsigned SHORT_LAST_DEFAULT = 5;

  typedef enum logic [1:0] {
    StClear,
    StIdle,
    StRun,
    StHalted
  } seq_state_e;

  // One-hot T-state vector with bit k set.
  function automatic logic [RING_W-1:0] t_state(input int unsigned k);
    logic [RING_W-1:0] one;
    one = {{(RING_W-1){1'b0}}, 1'b1};
    return one << k;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registers a level input and flags its rising edge for one cycle.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/timing_sequencer.sv
// T-state ring generator with clear/idle/run/halt control, closing the loop with the decoder.
module timing_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned SHORT_LAST   = SHORT_LAST_DEFAULT,
  parameter int unsigned CLEAR_CYCLES = 2,
  parameter int unsigned AUTO_RUN     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hlt_clk,
  input  logic              extended_fetch,
  input  logic              enable_ring_counter,
  input  logic              run_mode,
  input  logic              step,
  input  logic              start,
  output logic [RING_W-1:0] ring_counter,
  output logic              clear_pc,
  output logic              clear_inst_reg,
  output logic              instr_done,
  output logic              halted
);

  localparam logic [3:0] ClearLast = 4'(CLEAR_CYCLES - 1);
  localparam logic [RING_W-1:0] RingT0 = {{(RING_W-1){1'b0}}, 1'b1};

  seq_state_e        state;
  logic [3:0]        clear_cnt;
  logic              step_rise;
  logic              advance;
  logic              wrap;
  logic [RING_W-1:0] ring_next;

  edge_detect u_step_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (step),
    .rise (step_rise)
  );

  // Edges arriving in free-run are absorbed by the run_mode term, never queued.
  always_comb begin
    advance   = enable_ring_counter & (run_mode | step_rise);
    wrap      = ring_counter[RING_W-1] | (ring_counter[SHORT_LAST] & ~extended_fetch);
    ring_next = wrap ? RingT0 : (ring_counter << 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= StClear;
      ring_counter   <= '0;
      clear_pc       <= 1'b1;
      clear_inst_reg <= 1'b1;
      instr_done     <= 1'b0;
      halted         <= 1'b0;
      clear_cnt      <= '0;
    end else begin
      instr_done <= 1'b0;
      unique case (state)
        StClear: begin
          if (clear_cnt == ClearLast) begin
            clear_pc       <= 1'b0;
            clear_inst_reg <= 1'b0;
            if (AUTO_RUN != 0) begin
              state        <= StRun;
              ring_counter <= RingT0;
            end else begin
              state <= StIdle;
            end
          end else begin
            clear_cnt <= clear_cnt + 4'd1;
          end
        end
        StIdle: begin
          if (start) begin
            state        <= StRun;
            ring_counter <= RingT0;
          end
        end
        StRun: begin
          if (hlt_clk) begin
            state        <= StHalted;
            ring_counter <= '0;
            halted       <= 1'b1;
          end else if (advance) begin
            ring_counter <= ring_next;
            instr_done   <= wrap;
          end
        end
        StHalted: begin
          ring_counter <= '0;
        end
        default: begin
          state <= StClear;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timing_sequencer.sv
// Directed scoreboard bench: stimulus queues expected outputs, a negedge monitor checks them.
module tb_timing_sequencer;

  typedef struct packed {
    logic [9:0] ring;
    logic       cp;
    logic       ci;
    logic       done;
    logic       halt;
  } exp_t;

  logic       clk;
  logic       rst, hlt_clk, extended_fetch, enable_ring_counter, run_mode, step, start, start2;
  logic [9:0] ring_counter, ring2;
  logic       clear_pc, clear_inst_reg, instr_done, halted;
  logic       cp2, ci2, done2, halt2;

  exp_t       exp_q[$];
  logic [9:0] exp2_q[$];
  logic       pend2;
  logic [9:0] pend2_ring;
  int         n_tests;
  int         n_fail;
  int         n_chk;

  timing_sequencer dut (
    .clk                 (clk),
    .rst                 (rst),
    .hlt_clk             (hlt_clk),
    .extended_fetch      (extended_fetch),
    .enable_ring_counter (enable_ring_counter),
    .run_mode            (run_mode),
    .step                (step),
    .start               (start),
    .ring_counter        (ring_counter),
    .clear_pc            (clear_pc),
    .clear_inst_reg      (clear_inst_reg),
    .instr_done          (instr_done),
    .halted              (halted)
  );

  timing_sequencer #(.AUTO_RUN(0)) dut_idle (
    .clk                 (clk),
    .rst                 (rst),
    .hlt_clk             (1'b0),
    .extended_fetch      (1'b0),
    .enable_ring_counter (1'b1),
    .run_mode            (1'b1),
    .step                (1'b0),
    .start               (start2),
    .ring_counter        (ring2),
    .clear_pc            (cp2),
    .clear_inst_reg      (ci2),
    .instr_done          (done2),
    .halted              (halt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] t(input int k);
    logic [9:0] one;
    one = 10'd1;
    return one << k;
  endfunction

  // Outputs expected right after the coming rising edge.
  task automatic tick(input logic [9:0] r, input logic cp, input logic ci, input logic dn,
                      input logic hl);
    exp_t e;
    @(posedge clk);
    e.ring = r;
    e.cp   = cp;
    e.ci   = ci;
    e.done = dn;
    e.halt = hl;
    exp_q.push_back(e);
    if (pend2) begin
      exp2_q.push_back(pend2_ring);
      pend2 = 1'b0;
    end
    #1;
  endtask

  task automatic run_t(input int k);
    tick(t(k), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wrap_t0();
    tick(t(0), 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic expect2(input logic [9:0] r);
    pend2      = 1'b1;
    pend2_ring = r;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [9:0] r2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      n_tests++;
      if ({ring_counter, clear_pc, clear_inst_reg, instr_done, halted} !== e) begin
        n_fail++;
        $display("FAIL main#%0d: got ring=%h cp=%b ci=%b done=%b halt=%b, want ring=%h cp=%b ci=%b done=%b halt=%b",
                 n_chk, ring_counter, clear_pc, clear_inst_reg, instr_done, halted,
                 e.ring, e.cp, e.ci, e.done, e.halt);
      end
    end
    if (exp2_q.size() > 0) begin
      r2 = exp2_q.pop_front();
      n_tests++;
      if (ring2 !== r2) begin
        n_fail++;
        $display("FAIL auto_run0 ring: got %h, want %h", ring2, r2);
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_chk   = 0;
    pend2   = 1'b0;
    pend2_ring = '0;
    rst = 1'b1; hlt_clk = 1'b0; extended_fetch = 1'b0; enable_ring_counter = 1'b1;
    run_mode = 1'b1; step = 1'b0; start = 1'b0; start2 = 1'b0;

    // Reset, then clears held for two cycles and 6-cycle free-run period.
    tick(10'h000, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(10'h000, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    expect2(10'h000);
    tick(10'h000, 1'b1, 1'b1, 1'b0, 1'b0);
    expect2(10'h000);
    run_t(0);
    expect2(10'h000);
    run_t(1);
    start2 = 1'b1;
    expect2(t(0));
    run_t(2);
    start2 = 1'b0;
    expect2(t(1));
    run_t(3);
    run_t(4);
    run_t(5);
    wrap_t0();
    run_t(1);

    // Extended instruction runs to T9; the flag only matters at T5.
    extended_fetch = 1'b1;
    for (int k = 2; k <= 9; k++) run_t(k);
    wrap_t0();
    extended_fetch = 1'b0;
    run_t(1);

    // Decoder hold at T2 for three cycles.
    run_t(2);
    enable_ring_counter = 1'b0;
    for (int k = 0; k < 3; k++) run_t(2);
    enable_ring_counter = 1'b1;
    run_t(3);
    run_t(4);
    run_t(5);
    wrap_t0();

    // Single-step: one advance per rising edge, held level does nothing.
    run_mode = 1'b0;
    run_t(0);
    step = 1'b1;
    run_t(1);
    step = 1'b0;
    for (int k = 0; k < 4; k++) run_t(1);
    step = 1'b1;
    run_t(2);
    for (int k = 0; k < 4; k++) run_t(2);
    step = 1'b0;
    run_t(2);
    step = 1'b1;
    run_t(3);
    step = 1'b0;
    run_t(3);
    run_t(3);

    // Halt at T4; only reset leaves HALTED.
    run_mode = 1'b1;
    run_t(4);
    hlt_clk = 1'b1;
    tick(10'h000, 1'b0, 1'b0, 1'b0, 1'b1);
    hlt_clk = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step = k[0];
      tick(10'h000, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    step = 1'b0;
    rst = 1'b1;
    tick(10'h000, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    tick(10'h000, 1'b1, 1'b1, 1'b0, 1'b0);
    run_t(0);

    // Reset at T7 of an extended instruction restarts the clear sequence.
    extended_fetch = 1'b1;
    for (int k = 1; k <= 7; k++) run_t(k);
    rst = 1'b1;
    tick(10'h000, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    tick(10'h000, 1'b1, 1'b1, 1'b0, 1'b0);
    run_t(0);
    extended_fetch = 1'b0;
    run_t(1);

    for (int k = 0; k < 5 && (exp_q.size() > 0 || exp2_q.size() > 0); k++) @(posedge clk);
    if (exp_q.size() > 0 || exp2_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size() + exp2_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
